cache_opr_resp: RTL and testbench
=================================

CACHE_OPR_RESP -- requirements
Module: cache_opr_resp

Interface
REQ-001 Parameter TAG_LAT, default 3, SHALL set the tag-lookup latency in cycles; legal range 1..15.
REQ-002 Parameter MEM_TIMEOUT, default 255, SHALL set the maximum cycles to wait for mem_ack; legal range 1..255.
REQ-003 Port clk, input, 1: the single clock; all logic SHALL be rising-edge.
REQ-004 Port rstb, input, 1: reset, synchronous and active-high.
REQ-005 Port opr_1_pulse, input, 1: one-cycle start of stage 1 (tag lookup), driven by the operation controller.
REQ-006 Port opr_2_pulse, input, 1: one-cycle start of stage 2 (fill/writeback), driven by the operation controller.
REQ-007 Port lookup_hit, input, 1: tag-array hit indication, sampled only in the final LOOKUP cycle.
REQ-008 Port mem_ack, input, 1: memory-side completion strobe.
REQ-009 Port mem_req, output, 1: memory request, level, held until ack or timeout.
REQ-010 Port opr_finished, output, 1: one-cycle completion pulse back to the controller.
REQ-011 Port hit, output, 1: registered lookup result of the current/last operation.
REQ-012 Port timeout_err, output, 1: set with opr_finished when the memory wait timed out.
REQ-013 Port proto_err, output, 1: sticky flag for out-of-order pulses.
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOOKUP, WAIT_OPR2, MEM and DONE.
REQ-016 IDLE + opr_1_pulse SHALL go to LOOKUP, load the lookup counter to TAG_LAT-1, and clear hit, timeout_err and the pending flag.
REQ-017 LOOKUP SHALL decrement the counter each cycle; when the counter is 0 it SHALL register lookup_hit into hit and leave LOOKUP.
REQ-018 An opr_2_pulse during LOOKUP SHALL set a pending flag; at LOOKUP exit, pending causes the stage-2 decision (REQ-019) to be taken immediately; otherwise the FSM SHALL go to WAIT_OPR2.
REQ-019 Stage-2 decision, taken on opr_2_pulse in WAIT_OPR2 or via pending: hit=1 SHALL go to DONE; hit=0 SHALL go to MEM with the timer cleared.
REQ-020 MEM SHALL hold mem_req=1 and increment an 8-bit timer each cycle.
REQ-021 In MEM, mem_ack=1 SHALL go to DONE with timeout_err=0.
REQ-022 In MEM, timer==MEM_TIMEOUT-1 without mem_ack SHALL go to DONE with timeout_err=1.
REQ-023 In MEM, a simultaneous mem_ack and timeout SHALL be treated as ack.
REQ-024 DONE SHALL drive opr_finished=1 for exactly one cycle and then return to IDLE.
REQ-025 mem_req and opr_finished SHALL be Moore outputs decoded from the state register.
REQ-026 Latency, hit path: with opr_2_pulse in cycle t while in WAIT_OPR2, opr_finished SHALL be high in cycle t+1.
REQ-027 Latency, lookup: with opr_1_pulse in cycle t, hit SHALL be valid from cycle t+TAG_LAT+1.
REQ-028 opr_1_pulse outside IDLE, or opr_2_pulse in IDLE, MEM or DONE, SHALL be ignored and set proto_err.
REQ-029 mem_ack outside MEM SHALL be ignored.
REQ-030 proto_err SHALL clear only on reset.

Reset
REQ-031 When rstb=1 at a rising edge, the block SHALL return to IDLE with all counters and flags at 0, overriding any operation in progress.
REQ-032 After reset, mem_req, opr_finished, hit, timeout_err, proto_err and busy SHALL all be 0, and no opr_finished is emitted for an aborted operation.

Structure
REQ-033 A shared package cache_pkg SHALL hold the FSM state enum (opr_resp_state_t) and the default TAG_LAT and MEM_TIMEOUT constants.
REQ-034 The block SHALL contain one sub-module, opr_timer: a loadable down/up counter with a terminal-count flag, used for both the lookup counter and the memory timer.

Verification
REQ-035 Hit path: opr_1 at cycle 0, lookup_hit=1, opr_2 at cycle 6 -> hit=1 from cycle 4, opr_finished at cycle 7, mem_req never asserted.
REQ-036 Miss path: lookup_hit=0, opr_2 at cycle 6, mem_ack at cycle 12 -> mem_req high cycles 7..12, opr_finished at cycle 13, timeout_err=0.
REQ-037 Timeout: MEM_TIMEOUT=4, miss, no mem_ack -> mem_req high for 4 cycles, then opr_finished with timeout_err=1.
REQ-038 Early opr_2: opr_2 at cycle 1 during LOOKUP, hit=1 -> no WAIT_OPR2 state, opr_finished at cycle 4, proto_err=0.
REQ-039 Protocol/reset: opr_1 during MEM -> proto_err=1 and the operation completes normally; rstb during MEM -> no opr_finished is emitted, and all outputs are 0 the next cycle.
REQ-040 Boundary: ack coincident with the timeout cycle -> timeout_err=0.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and default timing constants for the cache operation blocks
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_OPR2, MEM, DONE} opr_resp_state_t;
  localparam int TAG_LAT_DEF = 3;
  localparam int MEM_TIMEOUT_DEF = 255;
endpackage

// File: rtl/opr_timer.sv
// opr_timer: loadable up/down counter with a terminal-count flag
module opr_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rstb) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= up ? count + 1'b1 : count - 1'b1;
  assign tc = count == term;
endmodule

// File: rtl/cache_opr_resp.sv
// cache_opr_resp: two-stage cache operation responder (tag lookup, then fill/writeback)
module cache_opr_resp
  import cache_pkg::*;
#(
  parameter int TAG_LAT = TAG_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rstb,
  input  logic opr_1_pulse,
  input  logic opr_2_pulse,
  input  logic lookup_hit,
  input  logic mem_ack,
  output logic mem_req,
  output logic opr_finished,
  output logic hit,
  output logic timeout_err,
  output logic proto_err,
  output logic busy
);
  localparam logic [7:0] LK_LOAD = 8'(TAG_LAT - 1);
  localparam logic [7:0] MEM_TERM = 8'(MEM_TIMEOUT - 1);
  opr_resp_state_t state, nxt;
  logic tc, load, en, up, pending, proto_evt;
  logic [7:0] load_val, term;
  // one counter serves both phases: counts down to 0 in LOOKUP, up to the timeout in MEM
  assign load = (state == IDLE && opr_1_pulse) || (nxt == MEM && state != MEM);
  assign en = state == LOOKUP || state == MEM;
  assign up = state == MEM;
  assign load_val = state == IDLE ? LK_LOAD : 8'd0;
  assign term = state == MEM ? MEM_TERM : 8'd0;
  assign proto_evt = (opr_1_pulse && state != IDLE) ||
                     (opr_2_pulse && (state == IDLE || state == MEM || state == DONE));
  opr_timer #(.W(8)) u_timer (
    .clk(clk), .rstb(rstb), .load(load), .en(en), .up(up),
    .load_val(load_val), .term(term), .tc(tc)
  );
  always_ff @(posedge clk)
    if (rstb) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = opr_1_pulse ? LOOKUP : IDLE;
      LOOKUP:    nxt = !tc ? LOOKUP : !(pending || opr_2_pulse) ? WAIT_OPR2 : lookup_hit ? DONE : MEM;
      WAIT_OPR2: nxt = !opr_2_pulse ? WAIT_OPR2 : hit ? DONE : MEM;
      MEM:       nxt = (mem_ack || tc) ? DONE : MEM;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    mem_req = state == MEM;
    opr_finished = state == DONE;
  end
  always_ff @(posedge clk)
    if (rstb) begin
      hit <= 1'b0;
      timeout_err <= 1'b0;
      pending <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (state == IDLE && opr_1_pulse) begin
        hit <= 1'b0;
        timeout_err <= 1'b0;
        pending <= 1'b0;
      end
      if (state == LOOKUP && opr_2_pulse) pending <= 1'b1;
      if (state == LOOKUP && tc) hit <= lookup_hit;
      if (state == MEM && nxt == DONE) timeout_err <= !mem_ack;
      if (proto_evt) proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_cache_opr_resp.sv
// tb_cache_opr_resp: randomized and directed checks against a transaction-level timing model
module tb_cache_opr_resp;
  localparam int TL = 3;
  logic clk = 1'b0;
  logic rstb, opr_1_pulse, opr_2_pulse, lookup_hit, mem_ack;
  logic mem_req_a, fin_a, hit_a, tout_a, proto_a, busy_a;
  logic mem_req_b, fin_b, hit_b, tout_b, proto_b, busy_b;
  logic [5:0] oa, ob;
  int errors = 0;
  int checks = 0;
  bit pe[2];
  always #5 clk = ~clk;
  cache_opr_resp #(.TAG_LAT(TL), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rstb(rstb), .opr_1_pulse(opr_1_pulse), .opr_2_pulse(opr_2_pulse),
    .lookup_hit(lookup_hit), .mem_ack(mem_ack), .mem_req(mem_req_a), .opr_finished(fin_a),
    .hit(hit_a), .timeout_err(tout_a), .proto_err(proto_a), .busy(busy_a)
  );
  cache_opr_resp #(.TAG_LAT(TL), .MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .rstb(rstb), .opr_1_pulse(opr_1_pulse), .opr_2_pulse(opr_2_pulse),
    .lookup_hit(lookup_hit), .mem_ack(mem_ack), .mem_req(mem_req_b), .opr_finished(fin_b),
    .hit(hit_b), .timeout_err(tout_b), .proto_err(proto_b), .busy(busy_b)
  );
  assign oa = {busy_a, mem_req_a, fin_a, hit_a, tout_a, proto_a};
  assign ob = {busy_b, mem_req_b, fin_b, hit_b, tout_b, proto_b};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    opr_1_pulse = 1'b0;
    opr_2_pulse = 1'b0;
    lookup_hit = 1'b0;
    mem_ack = 1'b0;
  endtask
  task automatic do_reset;
    rstb = 1'b1;
    tick;
    rstb = 1'b0;
    pe[0] = 1'b0;
    pe[1] = 1'b0;
  endtask
  // opr_1 at cycle 0, opr_2 at cycle p, ack ad cycles after the stage-2 decision (0 = none)
  task automatic run_op(input string nm, input int p, input bit h, input int ad,
                        input int x1, input int x2, input bit noise);
    int d, a, nmax;
    int e[2], f[2], mt[2];
    bit to[2];
    logic [5:0] want, got, m;
    mt[0] = 255;
    mt[1] = 4;
    d = (p <= TL) ? TL : p;
    a = ad > 0 ? d + ad : -1;
    nmax = 0;
    for (int k = 0; k < 2; k++) begin
      if (h) begin e[k] = d; to[k] = 1'b0; end
      else if (a >= d + 1 && a <= d + mt[k]) begin e[k] = a; to[k] = 1'b0; end
      else begin e[k] = d + mt[k]; to[k] = 1'b1; end
      f[k] = e[k] + 1;
      if (f[k] + 1 > nmax) nmax = f[k] + 1;
    end
    for (int c = 0; c <= nmax; c++) begin
      opr_1_pulse = c == 0 || c == x1;
      opr_2_pulse = c == p || c == x2;
      lookup_hit = c == TL ? h : (noise ? 1'($urandom) : 1'b0);
      mem_ack = c == a || (noise && c <= d && $urandom_range(0, 3) == 0);
      for (int k = 0; k < 2; k++) begin
        got = k == 0 ? oa : ob;
        want = {c >= 1 && c <= f[k], !h && c >= d + 1 && c <= e[k], c == f[k],
                c >= TL + 1 ? h : 1'b0, c >= f[k] ? to[k] : 1'b0, pe[k]};
        m = c == 0 ? 6'b111001 : 6'b111111;
        checks++;
        if ((got & m) !== (want & m)) begin
          errors++;
          $display("FAIL %s cyc=%0d dut%0d {busy,mem_req,fin,hit,tout,proto} got=%b want=%b",
                   nm, c, k, got & m, want & m);
        end
        if ((c == x1 && c >= 1) || (c == x2 && c >= d + 1)) pe[k] = 1'b1;
      end
      tick;
    end
    clear_inputs;
  endtask
  task automatic test_reset;
    clear_inputs;
    rstb = 1'b1;
    tick;
    tick;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ((k == 0 ? oa : ob) !== 6'b0) begin
        errors++;
        $display("FAIL reset dut%0d got=%b want=000000", k, k == 0 ? oa : ob);
      end
    end
    rstb = 1'b0;
    pe[0] = 1'b0;
    pe[1] = 1'b0;
    tick;
  endtask
  task automatic test_hit_path;       run_op("hit_path", 6, 1'b1, 0, -1, -1, 1'b0); endtask
  task automatic test_miss_path;      run_op("miss_path", 6, 1'b0, 6, -1, -1, 1'b0); endtask
  task automatic test_early_opr2;     run_op("early_opr2", 1, 1'b1, 0, -1, -1, 1'b0); endtask
  task automatic test_ack_boundary;   run_op("ack_at_timeout", 6, 1'b0, 4, -1, -1, 1'b0); endtask
  task automatic test_no_ack;         run_op("no_ack", 5, 1'b0, 0, -1, -1, 1'b0); endtask
  task automatic test_proto;
    do_reset;
    opr_2_pulse = 1'b1;
    tick;
    opr_2_pulse = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ((k == 0 ? oa : ob) !== 6'b000001) begin
        errors++;
        $display("FAIL opr2_in_idle dut%0d got=%b want=000001", k, k == 0 ? oa : ob);
      end
    end
    do_reset;
    run_op("opr1_in_mem", 6, 1'b0, 6, 8, -1, 1'b0);
    run_op("opr2_in_done", 2, 1'b1, 0, -1, 4, 1'b0);
  endtask
  task automatic test_reset_abort;
    do_reset;
    for (int c = 0; c <= 16; c++) begin
      opr_1_pulse = c == 0;
      opr_2_pulse = c == 6;
      mem_ack = c == 11;
      rstb = c == 8;
      if (c >= 9) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if ((k == 0 ? oa : ob) !== 6'b0) begin
            errors++;
            $display("FAIL reset_abort cyc=%0d dut%0d got=%b want=000000", c, k, k == 0 ? oa : ob);
          end
        end
      end
      tick;
    end
    rstb = 1'b0;
    clear_inputs;
    pe[0] = 1'b0;
    pe[1] = 1'b0;
  endtask
  task automatic test_random;
    int p, d, x1, x2;
    for (int i = 0; i < 25; i++) begin
      p = $urandom_range(1, 8);
      d = p <= TL ? TL : p;
      x1 = $urandom_range(0, 2) == 0 ? $urandom_range(1, d) : -1;
      x2 = $urandom_range(0, 2) == 0 ? $urandom_range(d + 1, d + 3) : -1;
      run_op("random", p, 1'($urandom), $urandom_range(1, 8), x1, x2, 1'b1);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_hit_path;
    test_miss_path;
    test_early_opr2;
    test_ack_boundary;
    test_no_ack;
    test_proto;
    test_reset_abort;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
